// File: rtl/bin_pkg.sv
// bin_pkg: shared definitions for the binning frame controller.
//   - FSM state encoding (state_t)
//   - error code values reported on err_code (err_code_t)
//   - default frame geometry, expected SRAM write count and watchdog limit
//   - counter widths used by the controller and its beat counter
package bin_pkg;

  localparam int DEF_IMG_W   = 640;
  localparam int DEF_IMG_H   = 480;
  localparam int DEF_N_BINS  = 784;
  localparam int DEF_TIMEOUT = 1 << 20;

  localparam int BEAT_W  = 19;  // holds IMG_W*IMG_H-1 = 307199
  localparam int WR_W    = 11;  // holds N_BINS = 784
  localparam int WD_W    = 20;  // idle-cycle watchdog
  localparam int FRAME_W = 16;  // completed-frame counter, wraps

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FIN    = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TLAST   = 2'd1,
    ERR_WRCNT   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

endpackage

// File: rtl/axis_beat_counter.sv
// axis_beat_counter: counts accepted pixel beats of one frame and checks
// that tlast lines up with the final beat.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   clr          - clears the count (frame start)
//   beat         - one accepted beat this cycle (tvalid && tready)
//   tlast        - tlast of the current beat
//   last_beat    - current beat is the final beat and carries tlast
//   tlast_err    - tlast is set on an earlier beat or missing on the final one
module axis_beat_counter
  import bin_pkg::*;
#(
  parameter int TOTAL_BEATS = DEF_IMG_W * DEF_IMG_H
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic beat,
  input  logic tlast,
  output logic last_beat,
  output logic tlast_err
);

  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(TOTAL_BEATS - 1);

  logic [BEAT_W-1:0] count_reg;
  logic              is_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (beat) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg is the index of the beat currently on the bus
  assign is_last   = (count_reg == LAST_IDX);
  assign last_beat = beat && is_last && tlast;
  assign tlast_err = beat && (tlast != is_last);

endmodule

// File: rtl/bin_frame_ctrl.sv
// bin_frame_ctrl: per-frame sequencer for the pixel binning datapath.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start, abort        - CPU frame request / unconditional return to IDLE
//   s_axis_*            - RGB pixel stream in (24-bit data, valid, last, ready)
//   m_axis_*            - pixel stream to the binning datapath
//   bin_start           - one-cycle start pulse to the datapath
//   bin_wr_en, bin_done - datapath SRAM write strobe and completion
//   busy, done          - not idle / one-cycle frame-complete pulse
//   err, err_code       - sticky error flag and cause (see err_code_t)
//   frame_cnt           - completed frames, wraps at 16 bits
module bin_frame_ctrl
  import bin_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int N_BINS  = DEF_N_BINS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [23:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic [23:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               bin_start,
  input  logic               bin_wr_en,
  input  logic               bin_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [WR_W-1:0] N_BINS_C = WR_W'(N_BINS);
  // TIMEOUT idle cycles have elapsed when the counter sits at TIMEOUT-1 and
  // the current cycle is idle too; this also keeps 2^20 within 20 bits.
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t             state_reg, state_next;
  err_code_t          err_code_reg, fault_code;
  logic               err_reg;
  logic [FRAME_W-1:0] frame_cnt_reg;
  logic [WR_W-1:0]    wr_cnt_reg;
  logic [WD_W-1:0]    wd_cnt_reg;

  logic in_stream, beat_acc, enter_arm, enter_fault;
  logic last_beat, tlast_err, wd_expired, activity;

  // Zero-latency pass-through, gated off outside STREAM
  assign in_stream     = (state_reg == ST_STREAM);
  assign s_axis_tready = in_stream && m_axis_tready;
  assign m_axis_tvalid = in_stream && s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  axis_beat_counter #(
    .TOTAL_BEATS(IMG_W * IMG_H)
  ) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (enter_arm),
    .beat     (beat_acc),
    .tlast    (s_axis_tlast),
    .last_beat(last_beat),
    .tlast_err(tlast_err)
  );

  assign wd_expired = (wd_cnt_reg == WD_LAST) && !beat_acc && !bin_wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fault_code = ERR_NONE;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_ARM;
      end
      ST_ARM: begin
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (tlast_err) begin
          state_next = ST_FAULT;
          fault_code = ERR_TLAST;
        end else if (bin_done) begin
          // datapath finished before the frame was fully streamed
          state_next = ST_FAULT;
          fault_code = ERR_WRCNT;
        end else if (wd_expired) begin
          state_next = ST_FAULT;
          fault_code = ERR_TIMEOUT;
        end else if (last_beat) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bin_done) begin
          if (wr_cnt_reg == N_BINS_C) begin
            state_next = ST_FIN;
          end else begin
            state_next = ST_FAULT;
            fault_code = ERR_WRCNT;
          end
        end else if (wd_expired) begin
          state_next = ST_FAULT;
          fault_code = ERR_TIMEOUT;
        end
      end
      ST_FIN:   state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // abort overrides every fault and normal transition and records nothing
    if (abort) begin
      state_next = ST_IDLE;
      fault_code = ERR_NONE;
    end
  end

  // ARM is only ever entered from IDLE, i.e. on an accepted start
  assign enter_arm   = (state_next == ST_ARM);
  assign enter_fault = (state_next == ST_FAULT);
  assign activity    = beat_acc || bin_wr_en || (state_next != state_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_reg <= '0;
    end else if (enter_arm) begin
      wr_cnt_reg <= '0;
    end else if ((state_reg != ST_IDLE) && bin_wr_en) begin
      wr_cnt_reg <= wr_cnt_reg + 1'b1;
    end
  end

  // Only counts in STREAM/DRAIN: every other non-idle state lasts one cycle,
  // so the state change clears it anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_reg <= '0;
    end else if ((state_reg == ST_IDLE) || activity) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else if (enter_arm) begin
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else if (enter_fault) begin
      err_reg      <= 1'b1;
      err_code_reg <= fault_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg <= '0;
    end else if ((state_reg == ST_FIN) && !abort) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_FIN) && !abort;
  assign bin_start = (state_reg == ST_ARM) && !abort;
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_bin_frame_ctrl.sv
// tb_bin_frame_ctrl: directed bench for bin_frame_ctrl on a reduced frame
// (8x4 pixels, 5 SRAM writes, 40-cycle watchdog) so whole frames stay short.
module tb_bin_frame_ctrl;

  localparam int TW = 8;
  localparam int TH = 4;
  localparam int TB = TW * TH;  // 32 beats per frame
  localparam int TN = 5;
  localparam int TT = 40;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tready;
  logic        bin_start, bin_wr_en, bin_done;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bin_frame_ctrl #(
    .IMG_W(TW), .IMG_H(TH), .N_BINS(TN), .TIMEOUT(TT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .bin_start    (bin_start),
    .bin_wr_en    (bin_wr_en),
    .bin_done     (bin_done),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .frame_cnt    (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // advance one clock; returns 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();            // now in ARM
    start = 1'b0;
    tick();            // now in STREAM
  endtask

  task automatic push_beats(input int first, input int n, input int last_idx);
    for (int i = first; i < first + n; i++) begin
      s_tdata  = 24'(i * 3 + 1);
      s_tlast  = (i == last_idx);
      s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wr_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bin_wr_en = 1'b1;
      tick();
    end
    bin_wr_en = 1'b0;
  endtask

  task automatic finish_frame(input int nwr);
    wr_pulses(nwr);
    bin_done = 1'b1;
    tick();
    bin_done = 1'b0;
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    s_tdata = '0; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
    bin_wr_en = 1'b0; bin_done = 1'b0;

    // reset values (valid/ready driven high to show gating)
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_bin_start", 32'(bin_start), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    s_tvalid = 1'b0;
    reset = 1'b0;
    tick();
    $display("step: reset values checked");

    // nominal frame
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_bin_start", 32'(bin_start), 32'd1);
    chk("arm_busy", 32'(busy), 32'd1);
    tick();
    chk("stream_bin_start", 32'(bin_start), 32'd0);
    s_tdata = 24'hABCDEF; s_tvalid = 1'b1; s_tlast = 1'b0;
    #1;
    chk("pass_tdata", 32'(m_tdata), 32'h00ABCDEF);
    chk("pass_tvalid", 32'(m_tvalid), 32'd1);
    chk("pass_tready", 32'(s_tready), 32'd1);
    tick();
    push_beats(1, TB - 1, TB - 1);
    chk("drain_tready", 32'(s_tready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    finish_frame(TN);
    chk("nom_done", 32'(done), 32'd1);
    tick();
    chk("nom_done_pulse", 32'(done), 32'd0);
    chk("nom_busy", 32'(busy), 32'd0);
    chk("nom_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("nom_err", 32'(err), 32'd0);
    $display("step: nominal frame, frame_cnt=%0d", frame_cnt);

    // early tlast on beat 10
    start_frame();
    push_beats(0, 11, 10);
    chk("tlast_err", 32'(err), 32'd1);
    chk("tlast_code", 32'(err_code), 32'd1);
    chk("tlast_tready", 32'(s_tready), 32'd0);
    tick();
    chk("tlast_idle", 32'(busy), 32'd0);
    chk("tlast_err_sticky", 32'(err), 32'd1);
    $display("step: early tlast, err_code=%0d", err_code);

    // one write short before bin_done
    start_frame();
    chk("restart_err_clr", 32'(err), 32'd0);
    chk("restart_code_clr", 32'(err_code), 32'd0);
    push_beats(0, TB, TB - 1);
    finish_frame(TN - 1);
    chk("wrcnt_done", 32'(done), 32'd0);
    chk("wrcnt_code", 32'(err_code), 32'd2);
    tick();
    chk("wrcnt_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("wrcnt_done_idle", 32'(done), 32'd0);
    $display("step: short write count, err_code=%0d", err_code);

    // source stalls after beat 5 until the watchdog fires
    start_frame();
    push_beats(0, 6, -1);
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("to_cycles", 32'(cyc), 32'(TT + 1));
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_code", 32'(err_code), 32'd3);
    chk("to_err", 32'(err), 32'd1);
    $display("step: timeout after %0d cycles", cyc);

    // downstream stalled: nothing counted until m_tready rises
    start_frame();
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 24'h123456;
    #1;
    chk("stall_m_tvalid", 32'(m_tvalid), 32'd1);
    chk("stall_s_tready", 32'(s_tready), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    m_tready = 1'b1;
    push_beats(0, TB, TB - 1);
    chk("stall_err", 32'(err), 32'd0);
    chk("stall_in_drain", 32'(busy), 32'd1);
    finish_frame(TN);
    chk("stall_done", 32'(done), 32'd1);
    tick();
    chk("stall_frame_cnt", 32'(frame_cnt), 32'd2);
    $display("step: stalled frame, frame_cnt=%0d", frame_cnt);

    // bin_done while still streaming
    start_frame();
    push_beats(0, 3, -1);
    bin_done = 1'b1;
    tick();
    bin_done = 1'b0;
    chk("early_done_code", 32'(err_code), 32'd2);
    tick();
    chk("early_done_idle", 32'(busy), 32'd0);
    $display("step: bin_done in stream, err_code=%0d", err_code);

    // second start ignored, abort mid-stream, then a clean frame
    start_frame();
    push_beats(0, 10, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", 32'(bin_start), 32'd0);
    chk("busy_still", 32'(busy), 32'd1);
    push_beats(10, 10, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'd2);
    tick();
    chk("abort_no_queue", 32'(busy), 32'd0);
    start_frame();
    push_beats(0, TB, TB - 1);
    finish_frame(TN);
    chk("fresh_done", 32'(done), 32'd1);
    tick();
    chk("fresh_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("fresh_err", 32'(err), 32'd0);
    $display("step: abort then fresh frame, frame_cnt=%0d", frame_cnt);

    // reset in DRAIN
    start_frame();
    push_beats(0, TB, TB - 1);
    wr_pulses(2);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    s_tvalid = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_code", 32'(err_code), 32'd0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_tready", 32'(s_tready), 32'd0);
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_bin_start", 32'(bin_start), 32'd0);
    tick();
    s_tvalid = 1'b0;
    reset = 1'b0;
    tick();
    $display("step: reset in drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
